// File: rtl/slow_mem_responder.sv
// slow_mem_responder
//
// Memory-side responder for the 128-bit cache line interface. One line
// transaction is accepted at a time. The responder holds it for LATENCY
// cycles and then pulses mem_ready for one cycle. On that pulse it either
// returns read data or commits the write. A backdoor port preloads
// program/data lines.
//
// Parameters:
//   LATENCY   cycles from the accept cycle to the mem_ready cycle (1..255)
//   LINE_AW   line-index width; storage holds 2^LINE_AW lines of 128 bits
//
// Ports:
//   clk         single clock, rising edge
//   proc_reset  synchronous active-high reset
//   mem_read    line read request (level, held until mem_ready)
//   mem_write   line write request (level, held until mem_ready)
//   mem_addr    line address [31:4]; bits [LINE_AW+3:4] index storage
//   mem_wdata   write line data
//   mem_rdata   read line data, valid in the mem_ready cycle of a read
//   mem_ready   one-cycle completion pulse
//   init_we     backdoor line write enable
//   init_addr   backdoor line index
//   init_data   backdoor line data
//   proto_err   sticky flag: read and write both requested at accept

module slow_mem_responder #(
    parameter int LATENCY = 8,
    parameter int LINE_AW = 8
) (
    input  logic               clk,
    input  logic               proc_reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:4]        mem_addr,
    input  logic [127:0]       mem_wdata,
    output logic [127:0]       mem_rdata,
    output logic               mem_ready,
    input  logic               init_we,
    input  logic [LINE_AW-1:0] init_addr,
    input  logic [127:0]       init_data,
    output logic               proto_err
);

    localparam int LINES = 1 << LINE_AW;

    // BUSY lasts LATENCY-1 cycles. The counter is loaded with LATENCY-2 and
    // the FSM leaves BUSY in the cycle where it reads zero.
    localparam logic [7:0] CNT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        READY
    } state_t;

    state_t             state, state_next;
    logic [7:0]         cnt, cnt_next;

    logic [LINE_AW-1:0] lat_idx;
    logic               lat_wr;
    logic [127:0]       lat_wdata;

    logic               accept;
    logic [LINE_AW-1:0] req_idx;
    logic [LINE_AW-1:0] rd_idx;
    logic               rd_is_read;

    logic [127:0]       storage [LINES];

    // Upper address bits alias onto the same lines, so they are deliberately dropped.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[31:LINE_AW+4];

    assign req_idx = mem_addr[LINE_AW+3:4];
    assign accept  = (state == IDLE) && (mem_read || mem_write);

    // Next-state logic. rd_idx/rd_is_read describe the transaction that is
    // about to enter READY. With LATENCY==1 that transaction is the one being
    // accepted right now, so it comes from the request inputs rather than
    // from the latches.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rd_idx     = lat_idx;
        rd_is_read = !lat_wr;
        case (state)
            IDLE: begin
                if (accept) begin
                    rd_idx     = req_idx;
                    rd_is_read = !mem_write;
                    if (LATENCY == 1) begin
                        state_next = READY;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == 8'd0) begin
                    state_next = READY;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            READY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Transaction latches. A simultaneous read+write is treated as a write
    // and raises the sticky protocol error.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            lat_idx   <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
            proto_err <= 1'b0;
        end else if (accept) begin
            lat_idx   <= req_idx;
            lat_wr    <= mem_write;
            lat_wdata <= mem_wdata;
            if (mem_read && mem_write) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Registered outputs. mem_rdata is loaded only when a read enters READY,
    // so it holds the last read value at all other times.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= (state_next == READY);
            if (state_next == READY && rd_is_read) begin
                mem_rdata <= storage[rd_idx];
            end
        end
    end

    // Line storage. The backdoor assignment comes last so that it wins
    // over a front-door commit to the same line in the same cycle.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            storage <= '{default: '0};
        end else begin
            if (state == READY && lat_wr) begin
                storage[lat_idx] <= lat_wdata;
            end
            if (init_we) begin
                storage[init_addr] <= init_data;
            end
        end
    end

endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder
//
// Self-checking bench for slow_mem_responder with LATENCY=4, LINE_AW=8.
// The stimulus process pushes the expected completion cycle and mem_rdata
// value into a scoreboard. A monitor checks each mem_ready pulse against
// the scoreboard entry at the head of the queue.

module tb_slow_mem_responder;

    localparam int LATENCY = 4;
    localparam int LINE_AW = 8;

    logic               clk;
    logic               proc_reset;
    logic               mem_read;
    logic               mem_write;
    logic [31:4]        mem_addr;
    logic [127:0]       mem_wdata;
    logic [127:0]       mem_rdata;
    logic               mem_ready;
    logic               init_we;
    logic [LINE_AW-1:0] init_addr;
    logic [127:0]       init_data;
    logic               proto_err;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    localparam logic [127:0] D10  = 128'hDEADBEEF_00000000_00000000_00000001;
    localparam logic [127:0] A5   = {16{8'hA5}};
    localparam logic [127:0] W30  = 128'h30303030_30303030_30303030_30303030;
    localparam logic [127:0] D31  = 128'h31313131_00000000_00000000_31313131;
    localparam logic [127:0] D05  = 128'h05050505_05050505_00000000_00000000;
    localparam logic [127:0] W50  = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam logic [127:0] ONE  = 128'h1;
    localparam logic [127:0] ZERO = 128'h0;

    slow_mem_responder #(
        .LATENCY(LATENCY),
        .LINE_AW(LINE_AW)
    ) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n starts at the n-th rising edge.
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every mem_ready pulse must match the head of the scoreboard
    // in both cycle and data. A head entry whose cycle has passed without a
    // pulse is reported as missing.
    always @(negedge clk) begin
        if (mem_ready) begin
            vectors = vectors + 1;
            if (sb.size() == 0) begin
                miscompares = miscompares + 1;
                $display("[TB] FAIL spurious_ready cycle=%0d rdata=%h required=no pulse", cyc, mem_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.cyc || mem_rdata !== e.data) begin
                    miscompares = miscompares + 1;
                    $display("[TB] FAIL ready_check cycle=%0d rdata=%h required cycle=%0d rdata=%h",
                             cyc, mem_rdata, e.cyc, e.data);
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("[TB] FAIL missing_ready required cycle=%0d, no pulse by cycle %0d", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Every stimulus task starts and ends 2 time units after a rising edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:4] addr,
                                 input logic [127:0] wdata, input logic [127:0] exp_rdata);
        exp_t e;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        e.cyc     = cyc + LATENCY;
        e.data    = exp_rdata;
        sb.push_back(e);
        repeat (LATENCY + 1) @(posedge clk);
        #2;
    endtask

    task automatic dropRequest();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [LINE_AW-1:0] idx, input logic [127:0] data);
        init_we   = 1'b1;
        init_addr = idx;
        init_data = data;
        @(posedge clk);
        #2;
        init_we = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        proc_reset  = 1'b1;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        init_we     = 1'b0;
        init_addr   = '0;
        init_data   = '0;
        repeat (2) @(posedge clk);
        #2;
        proc_reset = 1'b0;

        checkOutput("reset_ready", {127'd0, mem_ready}, ZERO);
        checkOutput("reset_rdata", mem_rdata, ZERO);
        checkOutput("reset_proto_err", {127'd0, proto_err}, ZERO);

        applyStimulus(1'b1, 1'b0, 28'h0000005, ZERO, ZERO);
        dropRequest();

        preload(8'h10, D10);
        preload(8'h31, D31);
        preload(8'h05, D05);

        applyStimulus(1'b1, 1'b0, 28'h0000010, ZERO, D10);
        dropRequest();

        // A write leaves the previously read value on mem_rdata.
        applyStimulus(1'b0, 1'b1, 28'h0000020, A5, D10);
        dropRequest();
        applyStimulus(1'b1, 1'b0, 28'h0000020, ZERO, A5);
        dropRequest();

        // Write-back switched straight into an allocate read.
        applyStimulus(1'b0, 1'b1, 28'h0000030, W30, A5);
        applyStimulus(1'b1, 1'b0, 28'h0000031, ZERO, D31);
        dropRequest();
        applyStimulus(1'b1, 1'b0, 28'h0000030, ZERO, W30);
        dropRequest();

        checkOutput("proto_err_clean", {127'd0, proto_err}, ZERO);
        applyStimulus(1'b1, 1'b1, 28'h0000040, ONE, W30);
        dropRequest();
        checkOutput("proto_err_set", {127'd0, proto_err}, ONE);
        applyStimulus(1'b1, 1'b0, 28'h0000040, ZERO, ONE);
        dropRequest();
        checkOutput("proto_err_sticky", {127'd0, proto_err}, ONE);

        // 0x105 aliases line 0x05.
        applyStimulus(1'b1, 1'b0, 28'h0000105, ZERO, D05);
        dropRequest();
        checkOutput("proto_err_sticky2", {127'd0, proto_err}, ONE);

        // Reset in the second BUSY cycle abandons the write.
        mem_write = 1'b1;
        mem_addr  = 28'h0000050;
        mem_wdata = W50;
        idleCycles(2);
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        idleCycles(1);
        proc_reset = 1'b0;
        checkOutput("rst_busy_ready", {127'd0, mem_ready}, ZERO);
        checkOutput("rst_busy_rdata", mem_rdata, ZERO);
        checkOutput("rst_busy_proto_err", {127'd0, proto_err}, ZERO);
        idleCycles(2 * LATENCY);

        applyStimulus(1'b1, 1'b0, 28'h0000050, ZERO, ZERO);
        dropRequest();
        applyStimulus(1'b1, 1'b0, 28'h0000020, ZERO, ZERO);
        dropRequest();

        idleCycles(LATENCY + 2);
        checkOutput("scoreboard_empty", 128'(sb.size()), ZERO);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/slow_mem_responder.md
# slow_mem_responder

Memory-side responder for the 128-bit line interface driven by the instruction and data caches (`mem_read`, `mem_write`, `mem_addr[31:4]`, `mem_wdata`, `mem_rdata`, `mem_ready`). It accepts one line transaction at a time, holds it for a fixed latency, then pulses `mem_ready`. On that pulse it either returns read data or commits the write. It sits at CHIP's `mem_*_I` / `mem_*_D` ports as a synthesizable replacement for the behavioural slow memory, with a backdoor port for program/data preload.

## Interface
- `LATENCY`, default 8: cycles from the accept cycle to the `mem_ready` cycle. Legal range 1..255.
- `LINE_AW`, default 8: line-index width. Storage is 2^LINE_AW lines of 128 bits.
- `clk` input 1: single clock, all state updates on rising edge.
- `proc_reset` input 1: reset, synchronous, active-high.
- `mem_read` input 1: line read request, level, held until `mem_ready`.
- `mem_write` input 1: line write request, level, held until `mem_ready`.
- `mem_addr` input [31:4]: line address. Bits [LINE_AW+3:4] index storage; upper bits are ignored (aliasing).
- `mem_wdata` input 128: write line data.
- `mem_rdata` output 128: read line data, valid in the `mem_ready` cycle of a read.
- `mem_ready` output 1: one-cycle completion pulse.
- `init_we` input 1: backdoor line write enable.
- `init_addr` input LINE_AW: backdoor line index.
- `init_data` input 128: backdoor line data.
- `proto_err` output 1: sticky flag, set when `mem_read` and `mem_write` are both high in an accept cycle.

## Operation
- States: IDLE, BUSY, READY.
- IDLE, with `mem_read|mem_write` high at the rising edge: accept. Latch the index, the type (write if `mem_write`, else read) and `mem_wdata`. Go to READY if LATENCY==1, else to BUSY with the down-counter loaded so that the FSM spends exactly LATENCY-1 cycles in BUSY.
- BUSY: count down, then go to READY. Request inputs are ignored; changes or drops during BUSY do not cancel or alter the latched transaction.
- READY (one cycle): `mem_ready`=1, then unconditionally go to IDLE.
  - Read: `mem_rdata` = storage[latched index], registered on entry to READY.
  - Write: storage[latched index] <= latched wdata at the end of the READY cycle.
- Both requests high at accept: the transaction is treated as a write, and `proto_err` is set and stays set until reset.
- The requester must drop or change its request in the cycle after `mem_ready`. The responder samples in IDLE that cycle, so a still-high request is taken as a new transaction. This allows a write-back immediately followed by an allocate read.
- `mem_rdata` holds its last read value outside READY and is not updated by writes.
- Backdoor write: applied at any edge, in any state. If it hits the same line as a front-door commit in the same cycle, the backdoor value wins. A read entering READY sees backdoor writes from earlier edges only.
- Reset: state goes to IDLE and the counter is cleared. `mem_ready`=0, `mem_rdata`=0, `proto_err`=0, all storage lines = 0. Reset during BUSY or READY abandons the transaction: no pulse after reset, no commit. Reset overrides a simultaneous backdoor write.

## Timing
- Request high in cycle 0 (IDLE) → `mem_ready` high in cycle LATENCY, for exactly one cycle.
- Read data is valid in the same cycle as `mem_ready`; written data is readable by any later transaction.
- Back-to-back throughput: one transaction per LATENCY+1 cycles (READY cycle, then the next accept in IDLE).
- `mem_ready` is never high in two consecutive cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset with LATENCY=4: all outputs 0; read of line 0x05 immediately after reset returns 128'h0.
- Backdoor `init_we`, index 0x10, data 128'hDEADBEEF_…_0001. Then `mem_read` with `mem_addr`=28'h0000010 in cycle 0 → `mem_ready` only in cycle 4, `mem_rdata`=written value; `mem_ready` low in cycles 1-3 and 5.
- Write 128'hA5…A5 to line 0x20, requester drops the request the cycle after `mem_ready`, then a read of line 0x20 → returns 128'hA5…A5; held `mem_rdata` is unchanged by the write.
- Write-back to line 0x30 immediately followed by a read of line 0x31, with the request switched in the cycle after the first `mem_ready` → second `mem_ready` exactly LATENCY+1 cycles after the first, correct data, no spurious extra transaction.
- Both `mem_read` and `mem_write` high with data 128'h1 on line 0x40 → write is performed; `proto_err`=1 and stays 1 through later clean transactions until `proto_err` clears on reset.
- Write issued, `proc_reset` asserted in cycle 2 of BUSY → no `mem_ready` afterwards and line reads 0. Separately, address 28'h0000105 with LINE_AW=8 aliases line 0x05.
